seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned divider: the inverse of the parameterized CLA adder datapath.

---
 rtl/div_pkg.sv | 15 +
 rtl/cla_subtractor.sv | 43 ++++
 rtl/seq_restoring_divider.sv | 133 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the iteration counter that counts NBITS-1 down to 0.
  function automatic int cnt_width(input int nbits);
    return (nbits <= 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational W-bit subtractor: a - b computed as a + ~b + 1 with a
// carry-lookahead carry network. borrow is high when b > a.
module cla_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         pp;
  logic         cc;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is expanded as a flat sum of generate terms gated by the
  // propagate chain above them, plus the fully propagated carry-in.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    pp   = 1'b1;
    cc   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      pp = 1'b1;
      cc = 1'b0;
      for (int unsigned k = 0; k <= i; k++) begin
        cc = cc | (g[i-k] & pp);
        pp = pp & p[i-k];
      end
      cc       = cc | (pp & c[0]);
      c[i+1]   = cc;
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle,
// valid/ready handshake on both sides.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations
// and flags div_by_zero while the result is presented.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(NBITS);
  localparam int W  = NBITS + 1;

  state_e           state_q, state_d;
  logic [NBITS-1:0] d_q, d_d;
  logic [NBITS-1:0] q_q, q_d;
  logic [W-1:0]     r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     r_sh;
  logic [W-1:0]     diff;
  logic             borrow;
`ifdef DIV_ZERO_SHORTCUT_EN
  logic             dbz_q, dbz_d;
`endif

  // Shift the next dividend bit into the partial remainder.
  assign r_sh = {r_q[NBITS-1:0], q_q[NBITS-1]};

  cla_subtractor #(.W(W)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, d_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_SHORTCUT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = CW'(NBITS - 1);
          state_d = CALC;
`ifdef DIV_ZERO_SHORTCUT_EN
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            q_d     = '1;
            r_d     = {1'b0, dividend};
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (!borrow) begin
          r_d = diff;
          q_d = {q_q[NBITS-2:0], 1'b1};
        end else begin
          r_d = r_sh;
          q_d = {q_q[NBITS-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
`ifdef DIV_ZERO_SHORTCUT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q[NBITS-1:0];
`ifdef DIV_ZERO_SHORTCUT_EN
  assign div_by_zero = dbz_q & out_valid;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider (NBITS=4) using a
// result scoreboard filled at the accept edge and drained at out_valid.
module tb_seq_restoring_divider;

  localparam int NBITS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] dividend;
  logic [NBITS-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] quotient;
  logic [NBITS-1:0] remainder;
  logic             div_by_zero;

  typedef struct packed {
    logic [NBITS-1:0] q;
    logic [NBITS-1:0] r;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  seq_restoring_divider #(.NBITS(NBITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
`ifdef DIV_ZERO_SHORTCUT_EN
      e.dbz = 1'b1;
`else
      e.dbz = 1'b0;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_lat(input logic [NBITS-1:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
    if (b == 0) return 1;
`endif
    return NBITS + 1;
  endfunction

  // Caller is at a negedge; returns just after the accept edge.
  task automatic send(input string tag, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready_before_accept"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    sb.push_back(model(a, b));
  endtask

  task automatic collect(input string tag, input int lat_exp);
    int   lat = 0;
    exp_t e;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (!out_valid) chk({tag, "_busy_in_ready"}, in_ready, 0);
    end while (!out_valid && lat < 50);
    chk({tag, "_latency"}, lat, lat_exp);
    chk({tag, "_done_in_ready"}, in_ready, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_div_by_zero"}, div_by_zero, e.dbz);
    end else begin
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
  endtask

  // Expects out_ready already high; DONE must leave to IDLE on the next edge.
  task automatic release_out(input string tag);
    @(negedge clk);
    chk({tag, "_idle_out_valid"}, out_valid, 0);
    chk({tag, "_idle_in_ready"}, in_ready, 1);
  endtask

  task automatic op(input string tag, input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    send(tag, a, b);
    collect(tag, exp_lat(b));
    release_out(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic divide
    op("t1_10_3", 4'd10, 4'd3);

    // 2: back-to-back operations, quotient zero case
    op("t2_11_4", 4'd11, 4'd4);
    op("t2_15_1", 4'd15, 4'd1);
    op("t2_3_8", 4'd3, 4'd8);

    // 3: backpressure with ignored input activity
    out_ready = 1'b0;
    send("t3_8_8", 4'd8, 4'd8);
    collect("t3_8_8", NBITS + 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      dividend = NBITS'($urandom);
      divisor  = NBITS'($urandom);
      @(negedge clk);
      chk("t3_hold_out_valid", out_valid, 1);
      chk("t3_hold_quotient", quotient, 1);
      chk("t3_hold_remainder", remainder, 0);
      chk("t3_hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    release_out("t3_release");
    @(negedge clk);
    chk("t3_no_queued_op", out_valid, 0);

    // 4: divide by zero
    op("t4_5_0", 4'd5, 4'd0);

    // 5: reset in the middle of an operation
    send("t5_14_3", 4'd14, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_quotient", quotient, 0);
    chk("t5_rst_remainder", remainder, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op("t5_14_3_again", 4'd14, 4'd3);

    // 6: every operand pair
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op("t6", NBITS'(a), NBITS'(b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
